vector_recorder: RTL and testbench

VECTOR_RECORDER -- requirements
Module: vector_recorder

---
 rtl/vector_recorder_if.sv | 27 ++
 rtl/vector_recorder.sv | 84 ++++++++
 tb/tb_vector_recorder.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vector_recorder_if.sv
// vector_recorder_if: capture/readout bus of the vector recorder
//   master (producer/consumer side): drives start, stop, sample_en, sample, rd_ready
//   slave (recorder side): drives rd_valid, rd_data, count, busy, full
interface vector_recorder_if #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 64
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic start;
  logic stop;
  logic sample_en;
  logic [WIDTH-1:0] sample;
  logic rd_valid;
  logic rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0] count;
  logic busy;
  logic full;
  modport master (
    output start, stop, sample_en, sample, rd_ready,
    input  rd_valid, rd_data, count, busy, full
  );
  modport slave (
    input  start, stop, sample_en, sample, rd_ready,
    output rd_valid, rd_data, count, busy, full
  );
endinterface

// File: rtl/vector_recorder.sv
// vector_recorder: captures up to DEPTH qualified sample vectors, then replays them in write order
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset, discards all stored records
//   bus   : vector_recorder_if.slave (start/stop/sample_en/sample in, rd_valid/rd_ready/rd_data readout,
//           count/busy/full status)
//   Optional macro VECREC_DEDUP_EN: skip samples equal to the last written record.
module vector_recorder #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 64
) (
  input logic clk,
  input logic reset,
  vector_recorder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] count_q, count_d, rd_ptr_q, rd_ptr_d;
  logic busy_q, full_q, rd_valid_q;
  logic [WIDTH-1:0] mem [DEPTH];
  logic keep, wr;
`ifdef VECREC_DEDUP_EN
  logic [WIDTH-1:0] last_q;
  assign keep = (count_q == '0) || (bus.sample != last_q);
  always_ff @(posedge clk)
    if (wr) last_q <= bus.sample;
`else
  assign keep = 1'b1;
`endif
  assign wr = (state_q == CAPTURE) && bus.sample_en && (count_q < DEPTH_C) && keep;
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = CAPTURE;
        count_d  = '0;
        rd_ptr_d = '0;
      end
      CAPTURE: begin
        count_d = wr ? count_q + 1'b1 : count_q;
        // the write that fills the buffer also ends capture
        state_d = (bus.stop || count_d == DEPTH_C) ? DRAIN : CAPTURE;
      end
      DRAIN: if (bus.start) begin
        state_d  = CAPTURE;
        count_d  = '0;
        rd_ptr_d = '0;
      end else if (rd_ptr_q == count_q) begin
        state_d = IDLE;
      end else if (bus.rd_ready) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // status outputs are registered from next-state values so they line up with state_q
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= state_d == CAPTURE;
      full_q     <= count_d == DEPTH_C;
      rd_valid_q <= (state_d == DRAIN) && (rd_ptr_d < count_d);
    end
  always_ff @(posedge clk)
    if (wr) mem[count_q[AW-1:0]] <= bus.sample;
  assign bus.rd_data  = mem[rd_ptr_q[AW-1:0]];
  assign bus.rd_valid = rd_valid_q;
  assign bus.count    = count_q;
  assign bus.busy     = busy_q;
  assign bus.full     = full_q;
endmodule

// File: tb/tb_vector_recorder.sv
// tb_vector_recorder: directed checks of capture, fill, backpressure, empty drain, async reset, dedup
module tb_vector_recorder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  vector_recorder_if #(.WIDTH(12), .DEPTH(64)) bus ();
  vector_recorder #(.WIDTH(12), .DEPTH(64)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [11:0] v);
    bus.sample_en = 1'b1;
    bus.sample = v;
    tick();
    bus.sample_en = 1'b0;
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask
  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask
  initial begin
    logic [11:0] dd [4];
    logic [11:0] de [4];
    logic [11:0] bp [3];
    logic rr [5];
    int n;
    int idx;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.sample_en = 1'b0;
    bus.sample = '0;
    bus.rd_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_valid", bus.rd_valid, 0);
    chk("rst_count", bus.count, 0);
    reset = 1'b0;
    tick();
    // stop in IDLE is ignored
    pulse_stop();
    chk("idle_stop_busy", bus.busy, 0);
    // basic capture, with a start in CAPTURE that must be ignored
    pulse_start();
    chk("cap_busy", bus.busy, 1);
    chk("cap_count0", bus.count, 0);
    put(12'h0A1);
    bus.start = 1'b1;
    put(12'h0A2);
    bus.start = 1'b0;
    put(12'h0A3);
    chk("cap_count3", bus.count, 3);
    chk("cap_valid", bus.rd_valid, 0);
    pulse_stop();
    chk("drn_busy", bus.busy, 0);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("basic_valid", bus.rd_valid, 1);
      chk("basic_data", bus.rd_data, 12'h0A1 + i);
      tick();
    end
    chk("basic_done_valid", bus.rd_valid, 0);
    tick();
    chk("basic_idle_count", bus.count, 3);
    chk("basic_idle_busy", bus.busy, 0);
    bus.rd_ready = 1'b0;
    // fill to DEPTH; samples 64..69 are dropped
    pulse_start();
    for (int i = 0; i < 70; i++) begin
      put(12'(i));
      if (i == 62) chk("fill_notfull", bus.full, 0);
      if (i == 63) begin
        chk("fill_full", bus.full, 1);
        chk("fill_busy", bus.busy, 0);
        chk("fill_count", bus.count, 64);
      end
    end
    chk("fill_count_hold", bus.count, 64);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      chk("fill_valid", bus.rd_valid, 1);
      chk("fill_data", bus.rd_data, i);
      tick();
    end
    chk("fill_end_valid", bus.rd_valid, 0);
    tick();
    chk("fill_idle_full", bus.full, 1);
    bus.rd_ready = 1'b0;
    // backpressure
    bp[0] = 12'h0B1; bp[1] = 12'h0B2; bp[2] = 12'h0B3;
    rr[0] = 1'b1; rr[1] = 1'b0; rr[2] = 1'b0; rr[3] = 1'b1; rr[4] = 1'b1;
    pulse_start();
    for (int i = 0; i < 3; i++) put(bp[i]);
    pulse_stop();
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      bus.rd_ready = rr[k];
      chk("bp_valid", bus.rd_valid, idx < 3);
      if (idx < 3) chk("bp_data", bus.rd_data, bp[idx]);
      tick();
      if (idx < 3 && rr[k]) idx++;
    end
    chk("bp_transfers", idx, 3);
    chk("bp_end_valid", bus.rd_valid, 0);
    bus.rd_ready = 1'b0;
    tick();
    // empty capture
    pulse_start();
    pulse_stop();
    chk("empty_valid", bus.rd_valid, 0);
    chk("empty_busy", bus.busy, 0);
    chk("empty_count", bus.count, 0);
    tick();
    // stop together with a sample still records it
    pulse_start();
    bus.stop = 1'b1;
    put(12'h5F0);
    bus.stop = 1'b0;
    chk("sim_count", bus.count, 1);
    chk("sim_valid", bus.rd_valid, 1);
    chk("sim_data", bus.rd_data, 12'h5F0);
    chk("sim_busy", bus.busy, 0);
    // start in DRAIN abandons readout
    pulse_start();
    chk("restart_busy", bus.busy, 1);
    chk("restart_count", bus.count, 0);
    chk("restart_valid", bus.rd_valid, 0);
    pulse_stop();
    tick();
    // async reset mid-drain
    pulse_start();
    put(12'h0C1);
    put(12'h0C2);
    pulse_stop();
    chk("ar_pre_valid", bus.rd_valid, 1);
    chk("ar_pre_count", bus.count, 2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", bus.rd_valid, 0);
    chk("ar_count", bus.count, 0);
    chk("ar_busy", bus.busy, 0);
    tick();
    reset = 1'b0;
    tick();
    // dedup behaviour depends on the build
    dd[0] = 12'h111; dd[1] = 12'h111; dd[2] = 12'h222; dd[3] = 12'h111;
`ifdef VECREC_DEDUP_EN
    n = 3;
    de[0] = 12'h111; de[1] = 12'h222; de[2] = 12'h111; de[3] = 12'h000;
`else
    n = 4;
    de[0] = 12'h111; de[1] = 12'h111; de[2] = 12'h222; de[3] = 12'h111;
`endif
    pulse_start();
    for (int i = 0; i < 4; i++) put(dd[i]);
    pulse_stop();
    chk("dd_count", bus.count, n);
    bus.rd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("dd_valid", bus.rd_valid, 1);
      chk("dd_data", bus.rd_data, de[i]);
      tick();
    end
    chk("dd_end_valid", bus.rd_valid, 0);
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
